// File: rtl/adder_error_monitor.sv
// Window error statistics for exact vs approximate adder results.
// Optional squared-error accumulation: define ERR_SQ_EN.
module adder_error_monitor #(
  parameter int N     = 16,
  parameter int LOG_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [N:0]         EXACT,
  input  logic [N:0]         APPROX,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [LOG_W:0]     ERR_CNT,
  output logic [N+LOG_W:0]   ED_SUM,
`ifdef ERR_SQ_EN
  output logic [N:0]         ED_MAX,
  output logic [2*N+1+LOG_W:0] SQ_SUM
`else
  output logic [N:0]         ED_MAX
`endif
);

  typedef enum logic {
    ACCUM  = 1'b0,
    REPORT = 1'b1
  } state_t;

  state_t r_state;
  state_t w_state_nxt;

  logic [LOG_W-1:0]   r_win;
  logic [LOG_W:0]     r_cnt_acc;
  logic [N+LOG_W:0]   r_sum_acc;
  logic [N:0]         r_max_acc;
  logic [LOG_W:0]     r_err_cnt;
  logic [N+LOG_W:0]   r_ed_sum;
  logic [N:0]         r_ed_max;

  logic [N:0]         w_ed;
  logic               w_nz;
  logic               w_accept;
  logic               w_last;
  logic [LOG_W:0]     w_cnt_nxt;
  logic [N+LOG_W:0]   w_sum_nxt;
  logic [N:0]         w_max_nxt;

  assign w_ed = (EXACT >= APPROX) ? (EXACT - APPROX)
                                  : (APPROX - EXACT);
  assign w_nz      = |w_ed;
  assign w_accept  = in_valid && (r_state == ACCUM) && !clr;
  assign w_last    = (r_win == '1);
  assign w_cnt_nxt = r_cnt_acc + (LOG_W+1)'(w_nz);
  assign w_sum_nxt = r_sum_acc + (N+1+LOG_W)'(w_ed);
  assign w_max_nxt = (w_ed > r_max_acc) ? w_ed : r_max_acc;

  assign in_ready  = (r_state == ACCUM);
  assign out_valid = (r_state == REPORT);
  assign ERR_CNT   = r_err_cnt;
  assign ED_SUM    = r_ed_sum;
  assign ED_MAX    = r_ed_max;

  always_comb begin
    w_state_nxt = r_state;
    if (clr) begin
      w_state_nxt = ACCUM;
    end else begin
      unique case (r_state)
        ACCUM:  if (w_accept && w_last) w_state_nxt = REPORT;
        REPORT: if (out_ready) w_state_nxt = ACCUM;
        default: w_state_nxt = ACCUM;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ACCUM;
    else        r_state <= w_state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_win     <= '0;
      r_cnt_acc <= '0;
      r_sum_acc <= '0;
      r_max_acc <= '0;
      r_err_cnt <= '0;
      r_ed_sum  <= '0;
      r_ed_max  <= '0;
    end else if (clr) begin
      r_win     <= '0;
      r_cnt_acc <= '0;
      r_sum_acc <= '0;
      r_max_acc <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        // result leaves with this sample folded in
        r_err_cnt <= w_cnt_nxt;
        r_ed_sum  <= w_sum_nxt;
        r_ed_max  <= w_max_nxt;
        r_win     <= '0;
        r_cnt_acc <= '0;
        r_sum_acc <= '0;
        r_max_acc <= '0;
      end else begin
        r_win     <= r_win + LOG_W'(1);
        r_cnt_acc <= w_cnt_nxt;
        r_sum_acc <= w_sum_nxt;
        r_max_acc <= w_max_nxt;
      end
    end
  end

`ifdef ERR_SQ_EN
  logic [2*N+1:0]       w_sq;
  logic [2*N+1+LOG_W:0] w_sq_nxt;
  logic [2*N+1+LOG_W:0] r_sq_acc;
  logic [2*N+1+LOG_W:0] r_sq_sum;

  assign w_sq     = {{(N+1){1'b0}}, w_ed} * {{(N+1){1'b0}}, w_ed};
  assign w_sq_nxt = r_sq_acc + (2*N+2+LOG_W)'(w_sq);
  assign SQ_SUM   = r_sq_sum;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sq_acc <= '0;
      r_sq_sum <= '0;
    end else if (clr) begin
      r_sq_acc <= '0;
    end else if (w_accept) begin
      if (w_last) begin
        r_sq_sum <= w_sq_nxt;
        r_sq_acc <= '0;
      end else begin
        r_sq_acc <= w_sq_nxt;
      end
    end
  end
`endif

endmodule
